// File: rtl/ascon_pack.sv
// Shared types and helpers for the Ascon job scheduler.
//   sched_state_e    : scheduler FSM states
//   sched_ptr_width  : width of the owner index and the round-robin pointer
package ascon_pack;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Run     = 2'd1,
    Hold    = 2'd2,
    Release = 2'd3
  } sched_state_e;

  // A single requester would give $clog2 = 0; keep at least one bit so that
  // vector declarations stay legal.
  function automatic int sched_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ascon_rr_arb.sv
// Combinational round-robin winner select.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at ptr_i+1 mod NumReq
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the granted requester
//   any_o   : at least one request present
module ascon_rr_arb #(
  parameter int NumReq = 2,
  parameter int PtrW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin : sel
    int cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    // Offsets 1..NumReq visit every requester once, ending on the last winner,
    // so the last winner has the lowest priority.
    for (int k = 1; k <= NumReq; k++) begin
      cand = (int'(ptr_i) + k) % NumReq;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = PtrW'(cand);
      end
    end
  end

endmodule

// File: rtl/ascon_job_sched.sv
// Round-robin job scheduler in front of the Ascon core controller.
// One job in flight at a time: Idle -> Run -> Hold -> Release -> Idle.
//   req_valid_i/req_ready_o : per-requester descriptor handshake
//   req_*_i                 : per-requester AD/PT block counts and start delay
//   done_o                  : one-cycle completion pulse to the job owner
//   core_ready_i            : core idle; gates new grants and leaving Release
//   core_tag_valid_i        : core finished; only observed in Run
//   core_start_o, core_*_o  : level start and latched configuration to the core
//   busy_o, owner_o         : job in flight, current/last granted requester
//   last_cycles_o           : Run-phase latency of the last job (saturating)
module ascon_job_sched
  import ascon_pack::*;
#(
  parameter int NumReq        = 2,
  parameter int DataAddrWidth = 7,
  parameter int DelayWidth    = 16,
  parameter int CycleWidth    = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][DataAddrWidth-1:0]  req_ad_size_i,
  input  logic [NumReq-1:0][DataAddrWidth-1:0]  req_pt_size_i,
  input  logic [NumReq-1:0][DelayWidth-1:0]     req_delay_i,
  output logic [NumReq-1:0]                     done_o,
  input  logic                                  core_ready_i,
  input  logic                                  core_tag_valid_i,
  output logic                                  core_start_o,
  output logic [DataAddrWidth-1:0]              core_ad_size_o,
  output logic [DataAddrWidth-1:0]              core_pt_size_o,
  output logic [DelayWidth-1:0]                 core_delay_o,
  output logic                                  busy_o,
  output logic [sched_ptr_width(NumReq)-1:0]    owner_o,
  output logic [CycleWidth-1:0]                 last_cycles_o
);

  localparam int PtrW = sched_ptr_width(NumReq);

  sched_state_e             state_reg, state_next;
  logic [PtrW-1:0]          ptr_reg, owner_reg;
  logic [CycleWidth-1:0]    cnt_reg, last_reg;
  logic                     start_reg;
  logic [DataAddrWidth-1:0] ad_reg, pt_reg;
  logic [DelayWidth-1:0]    dly_reg;

  logic [NumReq-1:0]        win_grant;
  logic [PtrW-1:0]          win_idx;
  logic                     win_any;
  logic                     handshake;

  ascon_rr_arb #(
    .NumReq (NumReq),
    .PtrW   (PtrW)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_reg),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    state_next  = state_reg;
    handshake   = 1'b0;
    req_ready_o = '0;
    case (state_reg)
      Idle: begin
        if (core_ready_i && win_any) begin
          handshake   = 1'b1;
          req_ready_o = win_grant;
          state_next  = Run;
        end
      end
      Run:     if (core_tag_valid_i) state_next = Hold;
      Hold:    state_next = Release;
      // Leaving Release lands in Idle; the next grant can happen there at the
      // earliest, so done and ready never share a cycle.
      Release: if (core_ready_i) state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= Idle;
      ptr_reg   <= PtrW'(NumReq - 1);
      owner_reg <= '0;
      cnt_reg   <= '0;
      last_reg  <= '0;
      start_reg <= 1'b0;
      ad_reg    <= '0;
      pt_reg    <= '0;
      dly_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Start is held through Hold so the core keeps its tag valid.
      start_reg <= (state_next == Run) || (state_next == Hold);
      if (handshake) begin
        ad_reg    <= req_ad_size_i[win_idx];
        pt_reg    <= req_pt_size_i[win_idx];
        dly_reg   <= req_delay_i[win_idx];
        owner_reg <= win_idx;
        ptr_reg   <= win_idx;
        cnt_reg   <= '0;
      end else if (state_reg == Run && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == Hold) last_reg <= cnt_reg;
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_done
    assign done_o[gi] = (state_reg == Hold) && (owner_reg == PtrW'(gi));
  end

  assign busy_o         = (state_reg != Idle);
  assign owner_o        = owner_reg;
  assign core_start_o   = start_reg;
  assign core_ad_size_o = ad_reg;
  assign core_pt_size_o = pt_reg;
  assign core_delay_o   = dly_reg;
  assign last_cycles_o  = last_reg;

endmodule

// File: tb/tb_ascon_job_sched.sv
module tb_ascon_job_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][6:0]   ad_in, pt_in;
  logic [1:0][15:0]  dly_in;
  logic [1:0]        done;
  logic              core_ready, core_tag_valid, core_start;
  logic [6:0]        core_ad, core_pt;
  logic [15:0]       core_dly;
  logic              busy;
  logic [0:0]        owner;
  logic [23:0]       last_cycles;

  // Second instance with a 4-bit latency counter, sharing all inputs.
  logic [1:0]        s_ready, s_done;
  logic              s_start, s_busy;
  logic [6:0]        s_ad, s_pt;
  logic [15:0]       s_dly;
  logic [0:0]        s_owner;
  logic [3:0]        s_last;

  always #5 clk = ~clk;

  ascon_job_sched dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ad_size_i(ad_in), .req_pt_size_i(pt_in), .req_delay_i(dly_in),
    .done_o(done), .core_ready_i(core_ready), .core_tag_valid_i(core_tag_valid),
    .core_start_o(core_start), .core_ad_size_o(core_ad), .core_pt_size_o(core_pt),
    .core_delay_o(core_dly), .busy_o(busy), .owner_o(owner), .last_cycles_o(last_cycles)
  );

  ascon_job_sched #(.CycleWidth(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(s_ready),
    .req_ad_size_i(ad_in), .req_pt_size_i(pt_in), .req_delay_i(dly_in),
    .done_o(s_done), .core_ready_i(core_ready), .core_tag_valid_i(core_tag_valid),
    .core_start_o(s_start), .core_ad_size_o(s_ad), .core_pt_size_o(s_pt),
    .core_delay_o(s_dly), .busy_o(s_busy), .owner_o(s_owner), .last_cycles_o(s_last)
  );

  typedef struct {
    logic [1:0]       valid;
    logic [1:0][6:0]  ad;
    logic [1:0][6:0]  pt;
    logic [1:0][15:0] dly;
    int               exp_owner;
    int               run_cycles;
  } vec_t;

  typedef struct {
    int owner;
    int cycles;
  } sb_t;

  vec_t vecs[7];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a descriptor set in Idle, check the same-cycle grant, then check
  // the latched configuration in the first Run cycle.
  task automatic do_handshake(input vec_t v);
    sb_t e;
    req_valid  = v.valid;
    ad_in      = v.ad;
    pt_in      = v.pt;
    dly_in     = v.dly;
    core_ready = 1'b1;
    #1;
    chk("grant", req_ready, 64'(2'b01 << v.exp_owner));
    chk("idle_busy", busy, 0);
    e.owner  = v.exp_owner;
    e.cycles = v.run_cycles;
    sb_q.push_back(e);
    step();
    core_ready = 1'b0;
    chk("start_run", core_start, 1);
    chk("core_ad", core_ad, v.ad[v.exp_owner]);
    chk("core_pt", core_pt, v.pt[v.exp_owner]);
    chk("core_dly", core_dly, v.dly[v.exp_owner]);
    chk("owner", owner, v.exp_owner);
    chk("run_busy", busy, 1);
  endtask

  // Stay in Run for n cycles, then complete through Hold and Release.
  task automatic run_to_done(input int n);
    sb_t e;
    for (int i = 1; i <= n; i++) begin
      if (i == 1) chk("no_ready_run", req_ready, 0);
      if (i == n) core_tag_valid = 1'b1;
      step();
    end
    core_tag_valid = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk("done", done, 64'(2'b01 << e.owner));
    chk("start_hold", core_start, 1);
    chk("no_ready_hold", req_ready, 0);
    step();
    chk("start_rel", core_start, 0);
    chk("rel_busy", busy, 1);
    chk("done_clr", done, 0);
    chk("last_cycles", last_cycles, e.cycles);
    chk("sat_last", s_last, (e.cycles > 15) ? 15 : e.cycles);
    $display("job owner=%0d cycles=%0d last=%0d sat_last=%0d", e.owner, e.cycles,
             last_cycles, s_last);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rel_wait", core_start, 0);
    end
    core_ready = 1'b1;
    #1;
    chk("no_grant_rel", req_ready, 0);
    step();
    req_valid = 2'b00;
    chk("back_idle", busy, 0);
  endtask

  initial begin
    // desc fields are {requester1, requester0}
    vecs[0] = '{2'b01, {7'd9, 7'd3},  {7'd4, 7'd2},  {16'd7, 16'd5},    0, 40};
    vecs[1] = '{2'b11, {7'd11, 7'd1}, {7'd12, 7'd6}, {16'd300, 16'd2},  1, 3};
    vecs[2] = '{2'b11, {7'd11, 7'd1}, {7'd12, 7'd6}, {16'd300, 16'd2},  0, 1};
    vecs[3] = '{2'b11, {7'd127, 7'd0},{7'd0, 7'd127},{16'hffff, 16'd0}, 1, 20};
    vecs[4] = '{2'b11, {7'd127, 7'd0},{7'd0, 7'd127},{16'hffff, 16'd0}, 0, 2};
    vecs[5] = '{2'b01, {7'd8, 7'd5},  {7'd8, 7'd5},  {16'd8, 16'd1234}, 0, 5};
    vecs[6] = '{2'b10, {7'd33, 7'd8}, {7'd44, 7'd8}, {16'd55, 16'd8},   1, 15};

    rst = 1'b1;
    req_valid = '0; ad_in = '0; pt_in = '0; dly_in = '0;
    core_ready = 1'b0; core_tag_valid = 1'b0;
    step();
    step();
    chk("rst_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_last", last_cycles, 0);
    chk("rst_done", done, 0);
    chk("rst_ad", core_ad, 0);
    rst = 1'b0;
    step();

    // Tag while Idle must not start anything.
    core_tag_valid = 1'b1;
    step();
    core_tag_valid = 1'b0;
    chk("idle_tag", busy, 0);

    for (int i = 0; i < 7; i++) begin
      do_handshake(vecs[i]);
      run_to_done(vecs[i].run_cycles);
    end

    // Core not ready: no grant for 10 cycles, grant in the first ready cycle.
    req_valid  = 2'b10;
    ad_in      = {7'd21, 7'd0};
    pt_in      = {7'd22, 7'd0};
    dly_in     = {16'd23, 16'd0};
    core_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("not_ready", req_ready, 0);
      step();
    end
    chk("not_ready_busy", busy, 0);
    begin
      vec_t v;
      v = '{2'b10, {7'd21, 7'd0}, {7'd22, 7'd0}, {16'd23, 16'd0}, 1, 6};
      do_handshake(v);
      run_to_done(6);
    end

    // Reset in the middle of a job; pointer must return to its reset value.
    begin
      vec_t v;
      v = '{2'b01, {7'd1, 7'd17}, {7'd1, 7'd18}, {16'd1, 16'd19}, 0, 10};
      do_handshake(v);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_start", core_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_last", last_cycles, 0);
      chk("mid_rst_ad", core_ad, 0);
      void'(sb_q.pop_front());
      step();
      rst = 1'b0;
      req_valid = 2'b00;
      step();
      v = '{2'b11, {7'd2, 7'd3}, {7'd4, 7'd5}, {16'd6, 16'd7}, 0, 4};
      do_handshake(v);
      run_to_done(4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the stimulus is fixed length, so this only fires on a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
